// File: rtl/vdp_sprite_pkg.sv
// Shared types for the sprite line renderer.
//   spinfo_t       : one 32-bit sprite info word as read from the info RAM
//   render_state_t : renderer sequencing states
//   SPINFO_*       : bit positions of the info word fields
package vdp_sprite_pkg;

   localparam int SPINFO_X_LSB   = 0;
   localparam int SPINFO_X_W     = 9;
   localparam int SPINFO_PAT_LSB = 9;
   localparam int SPINFO_PAT_W   = 16;
   localparam int SPINFO_COL_LSB = 25;
   localparam int SPINFO_COL_W   = 4;
   localparam int SPINFO_CC_BIT  = 29;
   localparam int SPINFO_IC_BIT  = 30;

   typedef struct packed {
      logic                    rsv;
      logic                    ic;
      logic                    cc;
      logic [SPINFO_COL_W-1:0] color;
      logic [SPINFO_PAT_W-1:0] pattern;
      logic [SPINFO_X_W-1:0]   x;
   } spinfo_t;

   typedef enum logic [1:0] {
      IDLE,
      PRELOAD,
      ACTIVE
   } render_state_t;

endpackage

// File: rtl/vdp_sprite_hit.sv
// Per-entry combinational hit test for one preloaded sprite.
//   info  : preloaded sprite info word
//   valid : entry holds a live sprite for this line
//   mag   : 1 = each pattern bit covers two dots
//   dot_x : current dot, 0..255
//   hit   : sprite has a set pattern bit on this dot
//   color, cc, ic : fields of the entry, passed through for resolution
module vdp_sprite_hit
   import vdp_sprite_pkg::*;
#(
   parameter int PAT_W = 16
) (
   input  spinfo_t    info,
   input  logic       valid,
   input  logic       mag,
   input  logic [8:0] dot_x,
   output logic       hit,
   output logic [3:0] color,
   output logic       cc,
   output logic       ic
);

   localparam int IW = $clog2(PAT_W);

   logic [9:0]       d;
   logic [9:0]       wid;
   logic [9:0]       idx;
   logic             in_range;
   logic [PAT_W-1:0] pat_sh;
   logic             unused_bits;

   always_comb begin
      // X is 9-bit two's complement, so sign-extend it against the zero-extended dot.
      d        = {1'b0, dot_x} - {info.x[8], info.x};
      wid      = mag ? 10'(2 * PAT_W) : 10'(PAT_W);
      in_range = !d[9] && (d < wid);
      idx      = mag ? {1'b0, d[9:1]} : d;
      // MSB of the pattern is the leftmost dot: shift the wanted bit up to the top.
      pat_sh   = PAT_W'(info.pattern) << idx[IW-1:0];
      hit      = valid && in_range && pat_sh[PAT_W-1];
   end

   assign color       = info.color;
   assign cc          = info.cc;
   assign ic          = info.ic;
   assign unused_bits = ^{info.rsv, idx[9:IW]};

endmodule

// File: rtl/vdp_sprite_line_render.sv
// Sprite line renderer: preloads up to NUM_SPR sprite info words at line start,
// then resolves per-dot sprite colour, visibility and collisions (mode-2 rules).
//   CLK21M, RESET_N  : clock, async active-low reset
//   LINE_START       : starts preload for the coming line
//   SP_COUNT         : number of live entries (0..NUM_SPR)
//   MAG, TP          : magnify, colour-0-displayable
//   DOT_EN, DOT_X    : dot strobe and dot position
//   INFO_ADDR/INFO_Q : info RAM read port (one clock read latency)
//   PRELOAD_BUSY     : high while preloading
//   SP_COLOR, SP_VALID, COLLISION, COL_X : registered per-dot results
//
// state   | meaning
// IDLE    | after reset, no line prepared, dots render transparent
// PRELOAD | stepping INFO_ADDR and capturing entries
// ACTIVE  | entries loaded, dots resolved against them
module vdp_sprite_line_render
   import vdp_sprite_pkg::*;
#(
   parameter int NUM_SPR = 8,
   parameter int PAT_W   = 16
) (
   input  logic                       CLK21M,
   input  logic                       RESET_N,
   input  logic                       LINE_START,
   input  logic [3:0]                 SP_COUNT,
   input  logic                       MAG,
   input  logic                       TP,
   input  logic                       DOT_EN,
   input  logic [8:0]                 DOT_X,
   output logic [$clog2(NUM_SPR)-1:0] INFO_ADDR,
   input  logic [31:0]                INFO_Q,
   output logic                       PRELOAD_BUSY,
   output logic [3:0]                 SP_COLOR,
   output logic                       SP_VALID,
   output logic                       COLLISION,
   output logic [8:0]                 COL_X
);

   localparam int AW = $clog2(NUM_SPR);
   localparam int SW = $clog2(NUM_SPR + 1);

   render_state_t        state;
   logic [SW-1:0]        step;
   logic [SW-1:0]        cap_num;
   logic [AW-1:0]        cap_idx;
   spinfo_t              entries [NUM_SPR];
   logic [NUM_SPR-1:0]   ent_valid;

   logic [NUM_SPR-1:0]   hit_w;
   logic [NUM_SPR-1:0]   cc_w;
   logic [NUM_SPR-1:0]   ic_w;
   logic [3:0]           col_w [NUM_SPR];

   logic                 base_found;
   logic                 chain;
   logic [3:0]           res_color;
   logic                 res_valid;
   logic                 coll_seen;
   logic                 coll;

   for (genvar g = 0; g < NUM_SPR; g++) begin : g_hit
      vdp_sprite_hit #(.PAT_W(PAT_W)) u_hit (
         .info  (entries[g]),
         .valid (ent_valid[g]),
         .mag   (MAG),
         .dot_x (DOT_X),
         .hit   (hit_w[g]),
         .color (col_w[g]),
         .cc    (cc_w[g]),
         .ic    (ic_w[g])
      );
   end

   // Lowest-index CC=0 hit is the base; CC=1 entries directly behind it OR in.
   // The chain is broken by the first CC=0 entry, hit or not.
   always_comb begin
      base_found = 1'b0;
      chain      = 1'b0;
      res_color  = 4'd0;
      coll_seen  = 1'b0;
      coll       = 1'b0;
      for (int i = 0; i < NUM_SPR; i++) begin
         if (!base_found) begin
            if (hit_w[i] && !cc_w[i]) begin
               base_found = 1'b1;
               chain      = 1'b1;
               res_color  = col_w[i];
            end
         end else if (chain) begin
            if (cc_w[i]) begin
               if (hit_w[i]) res_color = res_color | col_w[i];
            end else begin
               chain = 1'b0;
            end
         end
         if (hit_w[i] && !cc_w[i] && !ic_w[i]) begin
            if (coll_seen) coll = 1'b1;
            coll_seen = 1'b1;
         end
      end
      res_valid = base_found && ((res_color != 4'd0) || TP);
   end

   // Step s captures the entry addressed at step s-1 (RAM read latency of one clock).
   assign cap_num = SW'(step - SW'(1));
   assign cap_idx = AW'(cap_num);

   always_ff @(posedge CLK21M or negedge RESET_N) begin
      if (!RESET_N) begin
         state        <= IDLE;
         step         <= '0;
         INFO_ADDR    <= '0;
         PRELOAD_BUSY <= 1'b0;
         ent_valid    <= '0;
         for (int i = 0; i < NUM_SPR; i++) entries[i] <= '0;
         SP_COLOR     <= 4'd0;
         SP_VALID     <= 1'b0;
         COLLISION    <= 1'b0;
         COL_X        <= 9'd0;
      end else begin
         COLLISION <= 1'b0;
         if (DOT_EN) begin
            if ((state == ACTIVE) && !LINE_START) begin
               SP_COLOR <= res_color;
               SP_VALID <= res_valid;
               if (coll) begin
                  COLLISION <= 1'b1;
                  COL_X     <= DOT_X;
               end
            end else begin
               SP_COLOR <= 4'd0;
               SP_VALID <= 1'b0;
            end
         end

         if (LINE_START) begin
            state        <= PRELOAD;
            step         <= '0;
            INFO_ADDR    <= '0;
            PRELOAD_BUSY <= 1'b1;
            ent_valid    <= '0;
         end else begin
            case (state)
               PRELOAD: begin
                  if (step != '0) begin
                     entries[cap_idx]   <= spinfo_t'(INFO_Q);
                     ent_valid[cap_idx] <= (32'(cap_num) < 32'(SP_COUNT));
                  end
                  if (32'(step) == NUM_SPR) begin
                     state        <= ACTIVE;
                     step         <= '0;
                     INFO_ADDR    <= '0;
                     PRELOAD_BUSY <= 1'b0;
                  end else begin
                     step <= SW'(step + SW'(1));
                     if (32'(step) < NUM_SPR - 1) INFO_ADDR <= AW'(step + SW'(1));
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_vdp_sprite_line_render.sv
// Self-checking bench for vdp_sprite_line_render: a table of hand-derived dot
// vectors, a few multi-cycle sequences, and random lines against a reference model.
module tb_vdp_sprite_line_render;
   import vdp_sprite_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        line_start;
   logic [3:0]  sp_count;
   logic        mag;
   logic        tp;
   logic        dot_en;
   logic [8:0]  dot_x;
   logic [2:0]  info_addr;
   logic [31:0] info_q;
   logic        busy;
   logic [3:0]  sp_color;
   logic        sp_valid;
   logic        collision;
   logic [8:0]  col_x;

   always #5 clk = ~clk;

   vdp_sprite_line_render dut (
      .CLK21M       (clk),
      .RESET_N      (rst_n),
      .LINE_START   (line_start),
      .SP_COUNT     (sp_count),
      .MAG          (mag),
      .TP           (tp),
      .DOT_EN       (dot_en),
      .DOT_X        (dot_x),
      .INFO_ADDR    (info_addr),
      .INFO_Q       (info_q),
      .PRELOAD_BUSY (busy),
      .SP_COLOR     (sp_color),
      .SP_VALID     (sp_valid),
      .COLLISION    (collision),
      .COL_X        (col_x)
   );

   logic [31:0] ram [8];
   always @(posedge clk) info_q <= ram[info_addr];

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] m_words [8];
   int          m_count = 0;
   int          exp_colx = 0;
   bit          last_v = 0;

   typedef struct {
      int         scen;
      int         dot;
      bit         mag;
      bit         tp;
      bit         v;
      logic [3:0] c;
      bit         co;
   } vec_t;
   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mkw(input int x, input int pat, input int col,
                                       input bit cc, input bit ic);
      logic [31:0] w = '0;
      w[SPINFO_X_LSB +: 9]    = 9'(x);
      w[SPINFO_PAT_LSB +: 16] = 16'(pat);
      w[SPINFO_COL_LSB +: 4]  = 4'(col);
      w[SPINFO_CC_BIT]        = cc;
      w[SPINFO_IC_BIT]        = ic;
      return w;
   endfunction

   function automatic vec_t mkv(input int s, input int d, input bit m, input bit t,
                                input bit v, input int c, input bit co);
      vec_t r;
      r.scen = s; r.dot = d; r.mag = m; r.tp = t; r.v = v; r.c = 4'(c); r.co = co;
      return r;
   endfunction

   // Reference: decide each sprite's coverage from its signed position, then
   // apply base / CC-chain / collision rules on the list of entries.
   function automatic void model(input int dot, output bit v, output logic [3:0] c,
                                 output bit co);
      bit h [8];
      int base = -1;
      int ncoll = 0;
      int j;
      logic [3:0] res = 4'd0;
      for (int i = 0; i < 8; i++) begin
         int xs = int'(m_words[i][8:0]);
         int dd, w, p;
         if (xs >= 256) xs = xs - 512;
         dd = dot - xs;
         w  = mag ? 32 : 16;
         h[i] = 0;
         if (i < m_count && dd >= 0 && dd < w) begin
            p = mag ? dd / 2 : dd;
            h[i] = m_words[i][24 - p];
         end
      end
      for (int i = 0; i < 8; i++)
         if (base < 0 && h[i] && !m_words[i][29]) base = i;
      if (base >= 0) begin
         res = m_words[base][28:25];
         j = base + 1;
         while (j < 8 && m_words[j][29]) begin
            if (h[j]) res = res | m_words[j][28:25];
            j++;
         end
      end
      for (int i = 0; i < 8; i++)
         if (h[i] && !m_words[i][29] && !m_words[i][30]) ncoll++;
      v  = (base >= 0) && (res != 0 || tp);
      c  = res;
      co = (ncoll >= 2);
   endfunction

   // Called at a falling edge; returns at a falling edge after the preload ends.
   task automatic do_preload(input int cnt);
      int busy_cnt = 0;
      sp_count   = 4'(cnt);
      line_start = 1'b1;
      @(negedge clk);
      line_start = 1'b0;
      for (int n = 0; n < 12; n++) begin
         if (n < 8) chk("preload_addr", 32'(info_addr), n);
         if (busy) busy_cnt++;
         @(negedge clk);
      end
      chk("preload_busy_len", busy_cnt, 9);
      m_words = ram;
      m_count = cnt;
   endtask

   task automatic do_dot_raw(input int x);
      dot_en = 1'b1;
      dot_x  = 9'(x);
      @(negedge clk);
      dot_en = 1'b0;
   endtask

   task automatic do_dot_model(input int x);
      bit v, co;
      logic [3:0] c;
      model(x, v, c, co);
      do_dot_raw(x);
      chk("rand_valid", 32'(sp_valid), 32'(v));
      if (v) chk("rand_color", 32'(sp_color), 32'(c));
      chk("rand_collision", 32'(collision), 32'(co));
      if (co) exp_colx = x;
      chk("rand_col_x", 32'(col_x), exp_colx);
      last_v = v;
   endtask

   task automatic load_scen(input int s, output int cnt);
      for (int k = 0; k < 8; k++) ram[k] = mkw(0, 16'hFFFF, 15, 0, 0);
      cnt = 1;
      case (s)
         0: ram[0] = mkw(10, 16'h8001, 5, 0, 0);
         1: begin ram[0] = mkw(20, 16'hFFFF, 2, 0, 0); ram[1] = mkw(20, 16'hFFFF, 4, 1, 0); cnt = 2; end
         2: begin ram[0] = mkw(20, 16'hFFFF, 2, 0, 0); ram[1] = mkw(20, 16'hFFFF, 4, 0, 0); cnt = 2; end
         3: begin ram[0] = mkw(20, 16'hFFFF, 2, 0, 0); ram[1] = mkw(20, 16'hFFFF, 4, 0, 1); cnt = 2; end
         4: ram[0] = mkw(50, 16'hFFFF, 3, 1, 0);
         5: ram[0] = mkw(9'h1F8, 16'hFFFF, 7, 0, 0);
         6: ram[0] = mkw(100, 16'hFFFF, 0, 0, 0);
         7: begin
            for (int k = 0; k < 8; k++) ram[k] = mkw(k * 20, 16'hFFFF, k + 1, 0, 0);
            cnt = 3;
         end
         8: ram[0] = mkw(250, 16'hFFFF, 9, 0, 0);
         default: begin ram[0] = mkw(10, 16'hFFFF, 5, 0, 0); cnt = 0; end
      endcase
   endtask

   initial begin
      int cur_scen = -1;
      int cnt;
      int t;

      rst_n = 1'b0; line_start = 1'b0; sp_count = 4'd0; mag = 1'b0; tp = 1'b0;
      dot_en = 1'b0; dot_x = 9'd0;
      for (int k = 0; k < 8; k++) ram[k] = '0;
      #12;
      chk("reset_info_addr", 32'(info_addr), 0);
      chk("reset_busy", 32'(busy), 0);
      chk("reset_color", 32'(sp_color), 0);
      chk("reset_valid", 32'(sp_valid), 0);
      chk("reset_collision", 32'(collision), 0);
      chk("reset_col_x", 32'(col_x), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // ---------------- table-driven vectors ----------------
      vecs.push_back(mkv(0, 10, 0, 0, 1, 5, 0));
      vecs.push_back(mkv(0, 11, 0, 0, 0, 0, 0));
      vecs.push_back(mkv(0, 25, 0, 0, 1, 5, 0));
      vecs.push_back(mkv(0, 26, 0, 0, 0, 0, 0));
      vecs.push_back(mkv(0,  9, 0, 0, 0, 0, 0));
      vecs.push_back(mkv(0, 10, 1, 0, 1, 5, 0));
      vecs.push_back(mkv(0, 11, 1, 0, 1, 5, 0));
      vecs.push_back(mkv(0, 12, 1, 0, 0, 0, 0));
      vecs.push_back(mkv(0, 40, 1, 0, 1, 5, 0));
      vecs.push_back(mkv(0, 41, 1, 0, 1, 5, 0));
      vecs.push_back(mkv(0, 42, 1, 0, 0, 0, 0));
      vecs.push_back(mkv(1, 19, 0, 0, 0, 0, 0));
      vecs.push_back(mkv(1, 20, 0, 0, 1, 6, 0));
      vecs.push_back(mkv(1, 35, 0, 0, 1, 6, 0));
      vecs.push_back(mkv(1, 36, 0, 0, 0, 0, 0));
      vecs.push_back(mkv(2, 20, 0, 0, 1, 2, 1));
      vecs.push_back(mkv(2, 30, 0, 0, 1, 2, 1));
      vecs.push_back(mkv(2, 36, 0, 0, 0, 0, 0));
      vecs.push_back(mkv(3, 20, 0, 0, 1, 2, 0));
      vecs.push_back(mkv(4, 50, 0, 0, 0, 0, 0));
      vecs.push_back(mkv(4, 55, 0, 1, 0, 0, 0));
      vecs.push_back(mkv(5,  0, 0, 0, 1, 7, 0));
      vecs.push_back(mkv(5,  7, 0, 0, 1, 7, 0));
      vecs.push_back(mkv(5,  8, 0, 0, 0, 0, 0));
      vecs.push_back(mkv(6, 100, 0, 0, 0, 0, 0));
      vecs.push_back(mkv(6, 100, 0, 1, 1, 0, 0));
      vecs.push_back(mkv(6, 115, 0, 1, 1, 0, 0));
      vecs.push_back(mkv(6, 116, 0, 1, 0, 0, 0));
      vecs.push_back(mkv(7,  0, 0, 0, 1, 1, 0));
      vecs.push_back(mkv(7, 15, 0, 0, 1, 1, 0));
      vecs.push_back(mkv(7, 20, 0, 0, 1, 2, 0));
      vecs.push_back(mkv(7, 40, 0, 0, 1, 3, 0));
      vecs.push_back(mkv(7, 60, 0, 0, 0, 0, 0));
      vecs.push_back(mkv(8, 250, 0, 0, 1, 9, 0));
      vecs.push_back(mkv(8, 255, 0, 0, 1, 9, 0));
      vecs.push_back(mkv(8,  0, 0, 0, 0, 0, 0));
      vecs.push_back(mkv(9, 10, 0, 1, 0, 0, 0));

      foreach (vecs[i]) begin
         if (vecs[i].scen != cur_scen) begin
            cur_scen = vecs[i].scen;
            load_scen(cur_scen, cnt);
            do_preload(cnt);
         end
         mag = vecs[i].mag;
         tp  = vecs[i].tp;
         do_dot_raw(vecs[i].dot);
         chk($sformatf("vec%0d_valid", i), 32'(sp_valid), 32'(vecs[i].v));
         if (vecs[i].v) chk($sformatf("vec%0d_color", i), 32'(sp_color), 32'(vecs[i].c));
         chk($sformatf("vec%0d_collision", i), 32'(collision), 32'(vecs[i].co));
         if (vecs[i].co) exp_colx = vecs[i].dot;
         chk($sformatf("vec%0d_col_x", i), 32'(col_x), exp_colx);
      end

      // ---------------- LINE_START mid-preload restarts at address 0 ----------------
      mag = 1'b0; tp = 1'b0;
      load_scen(0, cnt);
      sp_count = 4'(cnt);
      line_start = 1'b1;
      @(negedge clk);
      line_start = 1'b0;
      t = 0;
      while (info_addr != 3'd4 && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("restart_reach_addr4", 32'(info_addr), 4);
      do_preload(cnt);
      do_dot_raw(10);
      chk("restart_dot10_valid", 32'(sp_valid), 1);
      chk("restart_dot10_color", 32'(sp_color), 5);

      // ---------------- LINE_START coinciding with DOT_EN ----------------
      line_start = 1'b1;
      dot_en     = 1'b1;
      dot_x      = 9'd10;
      @(negedge clk);
      line_start = 1'b0;
      dot_en     = 1'b0;
      chk("ls_dot_valid", 32'(sp_valid), 0);
      chk("ls_dot_busy", 32'(busy), 1);
      for (int n = 0; n < 11; n++) @(negedge clk);
      do_dot_raw(25);
      chk("after_ls_dot25_valid", 32'(sp_valid), 1);

      // ---------------- async reset during ACTIVE ----------------
      load_scen(2, cnt);
      do_preload(cnt);
      do_dot_raw(20);
      chk("pre_reset_collision", 32'(collision), 1);
      chk("pre_reset_col_x", 32'(col_x), 20);
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_valid", 32'(sp_valid), 0);
      chk("async_reset_color", 32'(sp_color), 0);
      chk("async_reset_collision", 32'(collision), 0);
      chk("async_reset_col_x", 32'(col_x), 0);
      @(negedge clk);
      rst_n = 1'b1;
      exp_colx = 0;
      @(negedge clk);
      do_dot_raw(20);
      chk("idle_dot_valid", 32'(sp_valid), 0);
      chk("idle_dot_collision", 32'(collision), 0);

      // ---------------- random lines against the reference model ----------------
      for (int r = 0; r < 24; r++) begin
         for (int k = 0; k < 8; k++) begin
            int xs = int'($urandom_range(0, 90)) - 20;
            if (r % 6 == 5) xs = int'($urandom_range(230, 255));
            ram[k] = mkw(xs, int'($urandom_range(0, 65535)), int'($urandom_range(0, 15)),
                         ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0));
            ram[k][31] = 1'($urandom_range(0, 1));
         end
         mag = 1'($urandom_range(0, 1));
         tp  = 1'($urandom_range(0, 1));
         do_preload(int'($urandom_range(0, 8)));
         for (int k = 0; k < 30; k++) begin
            if (k > 0 && $urandom_range(0, 3) == 0) begin
               @(negedge clk);
               chk("gap_collision", 32'(collision), 0);
               chk("gap_valid_hold", 32'(sp_valid), 32'(last_v));
            end
            if (r % 6 == 5) do_dot_model(int'($urandom_range(220, 255)));
            else            do_dot_model(int'($urandom_range(0, 110)));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/vdp_sprite_line_render.md
Name: vdp_sprite_line_render

Overview:
- Downstream consumer of the 8-entry sprite information memory, which holds the 32-bit sprite info words.
- At each line start it preloads up to 8 sprite info words into local registers.
- During the active line it produces a per-dot sprite colour, a valid flag and collision events, using V9938 mode-2 priority and CC/IC rules.
- Its output feeds the colour mixer.

Parameters:
- NUM_SPR, 8, number of info entries read per line; sets INFO_ADDR width as clog2.
- PAT_W, 16, pattern bits per sprite line; MSB is the leftmost dot.

Ports:
- CLK21M  in  1  system clock.
- RESET_N  in  1  asynchronous, active-low reset.
- LINE_START  in  1  one-clock pulse; starts preload for the coming line.
- SP_COUNT  in  4  number of valid entries, 0..8; entries at index >= SP_COUNT are ignored.
- MAG  in  1  1 = each pattern bit covers 2 dots (sprite width 32).
- TP  in  1  1 = colour 0 is displayable.
- DOT_EN  in  1  one-clock strobe per dot.
- DOT_X  in  9  current dot, 0..255, valid with DOT_EN.
- INFO_ADDR  out  3  read address to the info RAM.
- INFO_Q  in  32  read data; valid the clock after INFO_ADDR is presented.
- PRELOAD_BUSY  out  1  high while preloading.
- SP_COLOR  out  4  resolved sprite colour.
- SP_VALID  out  1  sprite dot present.
- COLLISION  out  1  one-clock pulse per collided dot.
- COL_X  out  9  DOT_X of the most recent collision.

Behaviour:
- Reset (asynchronous): state IDLE; all entry valid bits 0; INFO_ADDR=0; PRELOAD_BUSY=0; SP_COLOR=0; SP_VALID=0; COLLISION=0; COL_X=0.
- Info word layout: [8:0] X (9-bit two's complement, -256..255, early-clock shift already applied); [24:9] pattern; [28:25] colour; [29] CC; [30] IC; [31] reserved, ignored.
- FSM states: IDLE, PRELOAD, ACTIVE.
  - IDLE or ACTIVE --LINE_START--> PRELOAD.
  - PRELOAD: INFO_ADDR steps 0..7 on consecutive clocks. Entry k is captured the clock after address k is driven, and is marked valid iff k < SP_COUNT. The last capture is 9 clocks after entry, then the FSM goes to ACTIVE.
  - PRELOAD_BUSY=1 for exactly those 9 clocks.
  - LINE_START during PRELOAD restarts from address 0 and clears all valid bits.
  - ACTIVE stays ACTIVE until LINE_START.
- DOT_EN outside ACTIVE: SP_VALID=0, SP_COLOR=0, COLLISION=0.
- Hit test per entry in ACTIVE:
  - d = zext(DOT_X) - sext(X), computed 10-bit signed.
  - Width w = MAG ? 32 : 16.
  - Hit iff the entry is valid, 0 <= d < w, and pattern bit (15 - (MAG ? d>>1 : d)) = 1.
- Colour resolution:
  - Base = lowest-index hit with CC=0.
  - Result = base colour ORed with the colour of every hit entry j > base such that all entries base+1..j have CC=1 (the contiguous CC chain).
  - A CC=1 hit with no CC=0 base ahead of its chain is not displayed.
  - SP_VALID = base exists AND (result != 0 OR TP).
- Collision:
  - Occurs when two or more hits have CC=0 and IC=0 on the same dot.
  - COLLISION pulses for one clock; COL_X <= DOT_X.
  - COL_X holds its value across lines.
- Latency: SP_COLOR, SP_VALID and COLLISION are registered on the DOT_EN clock and are valid the next clock. They hold until the next DOT_EN, except that COLLISION drops after one clock.
- SP_COUNT=0: nothing valid, so SP_VALID stays 0.
- LINE_START coinciding with DOT_EN: LINE_START wins, and that dot outputs transparent.
- A sprite with X = 250 and MAG=0 is truncated at dot 255; there is no wrap to dot 0.

Decomposition:
- Package vdp_sprite_pkg:
  - typedef spinfo_t (packed struct matching the word layout);
  - localparams SPINFO_X_LSB and related bit positions;
  - enum render_state_t {IDLE, PRELOAD, ACTIVE}.
- One sub-module, vdp_sprite_hit: per-entry combinational hit test returning hit, colour, CC and IC; instantiated 8 times.
- Priority, CC chain and collision logic live in the top.

Test Plan:
- Preload: SP_COUNT=3, RAM entries 0..7 loaded → INFO_ADDR 0..7 over 8 clocks, PRELOAD_BUSY high 9 clocks, only entries 0..2 rendered.
- Single sprite, X=10, pattern 0x8001, colour 5, MAG=0 → SP_VALID=1 with colour 5 at dots 10 and 25 only; MAG=1 → dots 10, 11, 40, 41.
- Priority/CC: entry0 X=20 colour 2 CC=0, entry1 X=20 colour 4 CC=1, both patterns 0xFFFF → dots 20..35 colour 6, no COLLISION. With entry1 CC=0 instead → colour 2, COLLISION at dot 20, COL_X=20.
- IC: same overlap with entry1 IC=1, CC=0 → colour 2, no COLLISION. Lone CC=1 sprite → SP_VALID=0.
- Early clock: X=-8 (0x1F8), pattern 0xFFFF → dots 0..7 valid, dot 8 not. Colour 0 with TP=0 → SP_VALID=0; with TP=1 → 1.
- LINE_START issued mid-PRELOAD at address 4 → address restarts at 0; RESET_N low during ACTIVE → all outputs 0 immediately, without waiting for a clock edge.
